uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
Round-robin scheduler that shares one parity-enabled UART transmitter (8N1 plus parity, 11 bit periods per frame) between N byte requesters.
- Accepts bytes over per-requester valid/ready.
- Launches each frame with a single-cycle data-available pulse and waits for the transmitter's done pulse.
- Enforces a programmable inter-frame gap.
- Recovers from a hung transmitter with a watchdog timeout.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- CLKS_PER_BIT, 10, must match the transmitter's bit period
- GAP_CLKS, 2, idle clocks inserted after each frame (0 allowed)
- TIMEOUT_CLKS, 13*CLKS_PER_BIT, WAIT_DONE clocks before abort; must be > 11*CLKS_PER_BIT+1

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- req_valid  in  N_REQ  per-requester byte valid; held with data until accepted
- req_data  in  8*N_REQ  byte of requester i at bits [8i+7:8i]
- req_ready  out  N_REQ  one-hot accept, combinational, ARB state only
- tx_data_avail  out  1  registered one-cycle launch pulse to transmitter
- tx_data_byte  out  8  registered byte to transmitter
- tx_active  in  1  transmitter busy
- tx_done  in  1  transmitter one-cycle completion pulse
- grant_id  out  clog2(N_REQ)  index of requester owning the current/last frame
- busy  out  1  high in every state except ARB
- timeout_err  out  1  one-cycle pulse on watchdog abort

Behaviour:
- Reset values: state=ARB, tx_data_avail=0, tx_data_byte=0, grant_id=0, timeout_err=0, RR pointer=0 (requester 0 highest priority), counters=0.
- ARB state:
  - If any req_valid and tx_active=0, the arbiter picks the winner round-robin starting from the pointer.
  - req_ready[winner]=1 in the same cycle.
  - On the transfer (valid&ready), at the next edge: tx_data_byte<=req_data[winner], grant_id<=winner, pointer<=winner+1 (mod N_REQ), tx_data_avail<=1, state<=LAUNCH.
  - With tx_active=1 or no valid, req_ready=0 and the arbiter stays in ARB.
- LAUNCH: lasts exactly 1 cycle; tx_data_avail drops to 0 at the next edge; state<=WAIT_DONE and the timeout counter clears.
  - tx_data_avail is never high for more than one cycle, because the transmitter re-sends if it stays high.
- WAIT_DONE: the counter increments each cycle.
  - tx_done=1 → state<=GAP, or ARB if GAP_CLKS=0.
  - Counter reaches TIMEOUT_CLKS-1 without tx_done → timeout_err pulses 1 cycle and the state moves as on done.
  - tx_done and the timeout in the same cycle: done wins, no timeout_err.
- GAP: counts GAP_CLKS cycles, then returns to ARB. tx_done seen in GAP or ARB is ignored.
- Latency: request accept → tx_data_avail high is 1 clock. Frame start → tx_done is about 11*CLKS_PER_BIT+1 clocks.
- Byte throughput per frame: 1 accept cycle + 1 launch cycle + frame + GAP_CLKS.
- Fairness:
  - A requester that holds valid continuously gets a grant at least once every N_REQ frames.
  - A requester dropping valid before ready simply loses its turn; nothing is latched.
- Pointer wrap: N_REQ-1 → 0.
- Counter widths: clog2(TIMEOUT_CLKS+1) and clog2(GAP_CLKS+1), minimum 1 bit.
- Reset mid-operation:
  - Immediate return to ARB with all outputs at reset values.
  - An in-flight byte is lost.
  - The requester's handshake already completed, so no retry.
- req_data of non-granted requesters never affects the outputs.

Decomposition:
- Shared package uart_pkg holds:
  - state encoding ARB/LAUNCH/WAIT_DONE/GAP
  - FRAME_BITS=11
  - default CLKS_PER_BIT
- One sub-module, uart_rr_arbiter:
  - combinational one-hot round-robin pick from req vector and pointer
  - outputs a valid flag and an index
  - reusable for a future RX-side dispatcher

Test Plan (N_REQ=4, CLKS_PER_BIT=10, GAP_CLKS=2, real transmitter attached):
1. Single request: req_valid=0001, data0=8'hA5 → req_ready=0001 same cycle; tx_data_avail=1 for exactly 1 cycle next clock with tx_data_byte=A5; serial line carries A5 with parity 0; busy returns low 2 cycles after tx_done.
2. All four valid continuously, data 11/22/33/44 → grants 0,1,2,3,0 in order; tx_data_byte sequence 11,22,33,44,11; no two tx_data_avail pulses closer than 113 cycles.
3. Pointer wrap/fairness: after a grant to 2, requesters 0 and 3 valid → 3 granted before 0.
4. Hung transmitter: tx_done stubbed to 0 → timeout_err pulses once exactly 130 cycles after entering WAIT_DONE; next request is accepted 2 GAP cycles later.
5. Simultaneous tx_done and timeout in the final cycle → no timeout_err, normal GAP entry. Also: tx_active forced high in ARB with valid=1111 → req_ready stays 0000.
6. Reset asserted mid-frame (cycle 50 of WAIT_DONE) → outputs immediately at reset values; after release, requester 0 wins first regardless of the previous pointer.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART TX scheduling blocks: FSM encoding, frame
// geometry and counter-width helpers.
package uart_pkg;

   typedef enum logic [1:0] {
      ARB       = 2'd0,
      LAUNCH    = 2'd1,
      WAIT_DONE = 2'd2,
      GAP       = 2'd3
   } state_t;

   // start + 8 data + parity + stop
   localparam int FRAME_BITS           = 11;
   localparam int DEFAULT_CLKS_PER_BIT = 10;

   // Width of a counter that must hold 0..max_val, never narrower than 1 bit.
   function automatic int cnt_width(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

   // Width of an index into n items, never narrower than 1 bit.
   function automatic int idx_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/uart_rr_arbiter.sv
// Combinational round-robin pick: first set bit of req at or after ptr, wrapping.
// Zero latency; no state, so the caller owns the pointer and the handshake.
module uart_rr_arbiter
   import uart_pkg::*;
#(
   parameter int N  = 4,
   parameter int IW = idx_width(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic          pick_valid,
   output logic [IW-1:0] pick_idx,
   output logic [N-1:0]  pick_onehot
);

   always_comb begin
      pick_valid  = 1'b0;
      pick_idx    = '0;
      pick_onehot = '0;
      // Walk from the farthest offset back to the pointer so the closest
      // requester is the last (and therefore winning) assignment.
      for (int i = N - 1; i >= 0; i--) begin
         if (req[(int'(ptr) + i) % N]) begin
            pick_valid = 1'b1;
            pick_idx   = IW'((int'(ptr) + i) % N);
         end
      end
      pick_onehot[pick_idx] = pick_valid;
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART transmitter among N_REQ byte sources;
// accept-to-launch is 1 clock, and requesters see no ready while the TX is busy.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int N_REQ        = 4,
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
   parameter int GAP_CLKS     = 2,
   parameter int TIMEOUT_CLKS = 13 * CLKS_PER_BIT,
   localparam int IW          = idx_width(N_REQ)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [N_REQ-1:0]   req_valid,
   input  logic [8*N_REQ-1:0] req_data,
   output logic [N_REQ-1:0]   req_ready,
   output logic               tx_data_avail,
   output logic [7:0]         tx_data_byte,
   input  logic               tx_active,
   input  logic               tx_done,
   output logic [IW-1:0]      grant_id,
   output logic               busy,
   output logic               timeout_err
);

   // A watchdog shorter than one full frame would abort healthy transfers,
   // so it is never allowed below one frame plus the launch cycle.
   localparam int MIN_TIMEOUT  = FRAME_BITS * CLKS_PER_BIT + 2;
   localparam int TIMEOUT_EFF  = (TIMEOUT_CLKS >= MIN_TIMEOUT) ? TIMEOUT_CLKS : MIN_TIMEOUT;
   localparam int TW           = cnt_width(TIMEOUT_EFF);
   localparam int GW           = cnt_width(GAP_CLKS);

   state_t        state, state_n;
   logic [IW-1:0] ptr, ptr_n;
   logic [TW-1:0] tcnt, tcnt_n;
   logic [GW-1:0] gcnt, gcnt_n;
   logic          avail_n;
   logic [7:0]    byte_n;
   logic [IW-1:0] grant_n;
   logic          terr_n;

   logic             pick_valid;
   logic [IW-1:0]    pick_idx;
   logic [N_REQ-1:0] pick_onehot;

   uart_rr_arbiter #(
      .N  (N_REQ),
      .IW (IW)
   ) u_rr (
      .req         (req_valid),
      .ptr         (ptr),
      .pick_valid  (pick_valid),
      .pick_idx    (pick_idx),
      .pick_onehot (pick_onehot)
   );

   always_comb begin
      state_n   = state;
      ptr_n     = ptr;
      tcnt_n    = tcnt;
      gcnt_n    = gcnt;
      avail_n   = 1'b0;
      byte_n    = tx_data_byte;
      grant_n   = grant_id;
      terr_n    = 1'b0;
      req_ready = '0;

      case (state)
         ARB: begin
            if (pick_valid && !tx_active) begin
               req_ready = pick_onehot;
               byte_n    = req_data[8*int'(pick_idx) +: 8];
               grant_n   = pick_idx;
               ptr_n     = (int'(pick_idx) == N_REQ - 1) ? '0 : pick_idx + IW'(1);
               avail_n   = 1'b1;
               state_n   = LAUNCH;
            end
         end

         LAUNCH: begin
            tcnt_n  = '0;
            state_n = WAIT_DONE;
         end

         WAIT_DONE: begin
            // A done pulse in the final watchdog cycle still counts as success.
            if (tx_done || tcnt == TW'(TIMEOUT_EFF - 1)) begin
               terr_n  = !tx_done;
               gcnt_n  = '0;
               state_n = (GAP_CLKS == 0) ? ARB : GAP;
            end else begin
               tcnt_n = tcnt + TW'(1);
            end
         end

         GAP: begin
            if (gcnt == GW'(GAP_CLKS - 1)) begin
               state_n = ARB;
            end else begin
               gcnt_n = gcnt + GW'(1);
            end
         end

         default: state_n = ARB;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= ARB;
         ptr           <= '0;
         tcnt          <= '0;
         gcnt          <= '0;
         tx_data_avail <= 1'b0;
         tx_data_byte  <= '0;
         grant_id      <= '0;
         timeout_err   <= 1'b0;
      end else begin
         state         <= state_n;
         ptr           <= ptr_n;
         tcnt          <= tcnt_n;
         gcnt          <= gcnt_n;
         tx_data_avail <= avail_n;
         tx_data_byte  <= byte_n;
         grant_id      <= grant_n;
         timeout_err   <= terr_n;
      end
   end

   assign busy = (state != ARB);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a behavioural 8E1 transmitter model
// that can be bypassed for hung / manual done-pulse scenarios.
module tb_uart_tx_arbiter;

   localparam int N   = 4;
   localparam int CPB = 10;

   logic         clk = 1'b0;
   logic         reset;
   logic [3:0]   req_valid;
   logic [31:0]  req_data;
   logic [3:0]   req_ready;
   logic         tx_data_avail;
   logic [7:0]   tx_data_byte;
   logic         tx_active;
   logic         tx_done;
   logic [1:0]   grant_id;
   logic         busy;
   logic         timeout_err;

   logic         use_model;
   logic         man_active;
   logic         man_done;
   logic         m_active;
   logic         m_done;
   logic [10:0]  m_frame;
   int           m_bit;
   int           m_cnt;
   logic         tx_line;

   int           cyc = 0;
   int           n_checks = 0;
   int           n_pass = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   uart_tx_arbiter #(
      .N_REQ        (N),
      .CLKS_PER_BIT (CPB),
      .GAP_CLKS     (2),
      .TIMEOUT_CLKS (13 * CPB)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .req_valid     (req_valid),
      .req_data      (req_data),
      .req_ready     (req_ready),
      .tx_data_avail (tx_data_avail),
      .tx_data_byte  (tx_data_byte),
      .tx_active     (tx_active),
      .tx_done       (tx_done),
      .grant_id      (grant_id),
      .busy          (busy),
      .timeout_err   (timeout_err)
   );

   // Transmitter model: start, 8 data LSB first, even parity, stop.
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_active <= 1'b0;
         m_done   <= 1'b0;
         m_frame  <= '1;
         m_bit    <= 0;
         m_cnt    <= 0;
      end else begin
         m_done <= 1'b0;
         if (!m_active) begin
            if (tx_data_avail && use_model) begin
               m_frame  <= {1'b1, ^tx_data_byte, tx_data_byte, 1'b0};
               m_active <= 1'b1;
               m_bit    <= 0;
               m_cnt    <= 0;
            end
         end else if (m_cnt == CPB - 1) begin
            m_cnt <= 0;
            if (m_bit == 10) begin
               m_active <= 1'b0;
               m_done   <= 1'b1;
            end else begin
               m_bit <= m_bit + 1;
            end
         end else begin
            m_cnt <= m_cnt + 1;
         end
      end
   end

   assign tx_active = use_model ? m_active : man_active;
   assign tx_done   = use_model ? m_done   : man_done;
   assign tx_line   = m_active ? m_frame[m_bit] : 1'b1;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      reset     = 1'b1;
      req_valid = '0;
      man_active = 1'b0;
      man_done  = 1'b0;
      step();
      step();
      reset = 1'b0;
   endtask

   task automatic wait_avail(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (tx_data_avail) begin
            ok = 1'b1;
            break;
         end
         step();
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      #1;
      n_checks++; if (tx_data_avail !== 1'b0) $display("FAIL rst_avail: got %b want 0", tx_data_avail); else n_pass++;
      n_checks++; if (tx_data_byte !== 8'h00) $display("FAIL rst_byte: got %h want 00", tx_data_byte); else n_pass++;
      n_checks++; if (grant_id !== 2'd0) $display("FAIL rst_grant: got %0d want 0", grant_id); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else n_pass++;
      n_checks++; if (timeout_err !== 1'b0) $display("FAIL rst_terr: got %b want 0", timeout_err); else n_pass++;
      n_checks++; if (req_ready !== 4'b0000) $display("FAIL rst_ready: got %b want 0000", req_ready); else n_pass++;
   endtask

   task automatic test_single();
      logic [10:0] cap;
      logic [10:0] exp_frame;
      bit          seen;
      do_reset();
      use_model = 1'b1;
      req_data  = {8'h44, 8'h33, 8'h22, 8'hA5};
      req_valid = 4'b0001;
      #1;
      n_checks++; if (req_ready !== 4'b0001) $display("FAIL single_ready: got %b want 0001", req_ready); else n_pass++;
      step();
      req_valid = '0;
      n_checks++; if (tx_data_avail !== 1'b1) $display("FAIL single_avail: got %b want 1", tx_data_avail); else n_pass++;
      n_checks++; if (tx_data_byte !== 8'hA5) $display("FAIL single_byte: got %h want a5", tx_data_byte); else n_pass++;
      n_checks++; if (busy !== 1'b1) $display("FAIL single_busy_launch: got %b want 1", busy); else n_pass++;
      step();
      n_checks++; if (tx_data_avail !== 1'b0) $display("FAIL single_avail_drop: got %b want 0", tx_data_avail); else n_pass++;
      repeat (5) step();
      cap[0] = tx_line;
      for (int k = 1; k < 11; k++) begin
         repeat (CPB) step();
         cap[k] = tx_line;
      end
      exp_frame = {1'b1, 1'b0, 8'hA5, 1'b0};
      n_checks++; if (cap !== exp_frame) $display("FAIL single_serial: got %b want %b", cap, exp_frame); else n_pass++;
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (tx_done) begin
            seen = 1'b1;
            break;
         end
         step();
      end
      n_checks++; if (!seen) $display("FAIL single_done: got no tx_done want pulse"); else n_pass++;
      step();
      n_checks++; if (busy !== 1'b1) $display("FAIL single_gap1: got busy %b want 1", busy); else n_pass++;
      step();
      n_checks++; if (busy !== 1'b1) $display("FAIL single_gap2: got busy %b want 1", busy); else n_pass++;
      step();
      n_checks++; if (busy !== 1'b0) $display("FAIL single_idle: got busy %b want 0", busy); else n_pass++;
   endtask

   task automatic test_round_robin();
      logic [1:0] exp_g [5];
      logic [7:0] exp_b [5];
      int         last;
      bit         ok;
      exp_g = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      exp_b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
      do_reset();
      use_model = 1'b1;
      req_data  = {8'h44, 8'h33, 8'h22, 8'h11};
      req_valid = 4'hF;
      last = 0;
      for (int f = 0; f < 5; f++) begin
         wait_avail(ok);
         n_checks++; if (!ok) $display("FAIL rr_launch%0d: got no launch want launch", f); else n_pass++;
         n_checks++; if (grant_id !== exp_g[f]) $display("FAIL rr_grant%0d: got %0d want %0d", f, grant_id, exp_g[f]); else n_pass++;
         n_checks++; if (tx_data_byte !== exp_b[f]) $display("FAIL rr_byte%0d: got %h want %h", f, tx_data_byte, exp_b[f]); else n_pass++;
         if (f > 0) begin
            n_checks++; if (cyc - last < 113) $display("FAIL rr_spacing%0d: got %0d want >=113", f, cyc - last); else n_pass++;
         end
         last = cyc;
         step();
         n_checks++; if (tx_data_avail !== 1'b0) $display("FAIL rr_pulse%0d: got %b want 0", f, tx_data_avail); else n_pass++;
      end
      req_valid = '0;
   endtask

   task automatic test_wrap();
      bit ok;
      do_reset();
      use_model = 1'b1;
      req_data  = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
      req_valid = 4'b0100;
      #1;
      n_checks++; if (req_ready !== 4'b0100) $display("FAIL wrap_ready2: got %b want 0100", req_ready); else n_pass++;
      step();
      n_checks++; if (grant_id !== 2'd2) $display("FAIL wrap_grant2: got %0d want 2", grant_id); else n_pass++;
      req_valid = 4'b1001;
      step();
      wait_avail(ok);
      n_checks++; if (!ok || grant_id !== 2'd3) $display("FAIL wrap_grant3: got %0d (launch %b) want 3", grant_id, ok); else n_pass++;
      n_checks++; if (tx_data_byte !== 8'hD3) $display("FAIL wrap_byte3: got %h want d3", tx_data_byte); else n_pass++;
      step();
      wait_avail(ok);
      n_checks++; if (!ok || grant_id !== 2'd0) $display("FAIL wrap_grant0: got %0d (launch %b) want 0", grant_id, ok); else n_pass++;
      n_checks++; if (tx_data_byte !== 8'hA0) $display("FAIL wrap_byte0: got %h want a0", tx_data_byte); else n_pass++;
      req_valid = '0;
   endtask

   task automatic test_hung();
      int errs;
      do_reset();
      use_model = 1'b0;
      req_data  = {8'h44, 8'h33, 8'h22, 8'h5A};
      req_valid = 4'b0001;
      step();
      req_valid = '0;
      step();
      errs = 0;
      for (int i = 1; i < 130; i++) begin
         step();
         if (timeout_err) errs++;
      end
      n_checks++; if (errs != 0) $display("FAIL hung_early: got %0d pulses want 0", errs); else n_pass++;
      step();
      n_checks++; if (timeout_err !== 1'b1) $display("FAIL hung_terr: got %b want 1", timeout_err); else n_pass++;
      n_checks++; if (busy !== 1'b1) $display("FAIL hung_gap: got busy %b want 1", busy); else n_pass++;
      req_valid = 4'b0010;
      step();
      n_checks++; if (timeout_err !== 1'b0) $display("FAIL hung_pulse: got %b want 0", timeout_err); else n_pass++;
      n_checks++; if (req_ready !== 4'b0000) $display("FAIL hung_gap_ready: got %b want 0000", req_ready); else n_pass++;
      step();
      n_checks++; if (req_ready !== 4'b0010) $display("FAIL hung_accept: got %b want 0010", req_ready); else n_pass++;
      req_valid = '0;
      #1;
   endtask

   task automatic test_simultaneous();
      do_reset();
      use_model = 1'b0;
      req_data  = {8'h44, 8'h33, 8'h22, 8'h11};
      req_valid = 4'b0001;
      step();
      req_valid = '0;
      step();
      repeat (129) step();
      man_done = 1'b1;
      step();
      man_done = 1'b0;
      n_checks++; if (timeout_err !== 1'b0) $display("FAIL simul_terr: got %b want 0", timeout_err); else n_pass++;
      n_checks++; if (busy !== 1'b1) $display("FAIL simul_gap1: got busy %b want 1", busy); else n_pass++;
      step();
      n_checks++; if (busy !== 1'b1) $display("FAIL simul_gap2: got busy %b want 1", busy); else n_pass++;
      step();
      n_checks++; if (busy !== 1'b0) $display("FAIL simul_arb: got busy %b want 0", busy); else n_pass++;
      man_active = 1'b1;
      req_valid  = 4'hF;
      #1;
      n_checks++; if (req_ready !== 4'b0000) $display("FAIL active_ready: got %b want 0000", req_ready); else n_pass++;
      step();
      n_checks++; if (req_ready !== 4'b0000 || tx_data_avail !== 1'b0) $display("FAIL active_hold: got ready %b avail %b want 0000 0", req_ready, tx_data_avail); else n_pass++;
      man_active = 1'b0;
      #1;
      n_checks++; if (req_ready !== 4'b0010) $display("FAIL active_release: got %b want 0010", req_ready); else n_pass++;
      req_valid = '0;
      #1;
   endtask

   task automatic test_reset_mid();
      do_reset();
      use_model = 1'b1;
      req_data  = {8'h99, 8'h88, 8'h77, 8'h66};
      req_valid = 4'b0100;
      step();
      req_valid = '0;
      step();
      repeat (50) step();
      n_checks++; if (busy !== 1'b1 || grant_id !== 2'd2) $display("FAIL mid_pre: got busy %b grant %0d want 1 2", busy, grant_id); else n_pass++;
      #2;
      reset = 1'b1;
      #1;
      n_checks++; if (busy !== 1'b0) $display("FAIL mid_busy: got %b want 0", busy); else n_pass++;
      n_checks++; if (grant_id !== 2'd0) $display("FAIL mid_grant: got %0d want 0", grant_id); else n_pass++;
      n_checks++; if (tx_data_byte !== 8'h00) $display("FAIL mid_byte: got %h want 00", tx_data_byte); else n_pass++;
      n_checks++; if (tx_data_avail !== 1'b0 || timeout_err !== 1'b0) $display("FAIL mid_pulses: got avail %b terr %b want 0 0", tx_data_avail, timeout_err); else n_pass++;
      step();
      reset     = 1'b0;
      req_valid = 4'hF;
      #1;
      n_checks++; if (req_ready !== 4'b0001) $display("FAIL mid_first: got %b want 0001", req_ready); else n_pass++;
      step();
      n_checks++; if (grant_id !== 2'd0 || tx_data_byte !== 8'h66) $display("FAIL mid_launch: got grant %0d byte %h want 0 66", grant_id, tx_data_byte); else n_pass++;
      req_valid = '0;
   endtask

   initial begin
      reset      = 1'b1;
      req_valid  = '0;
      req_data   = '0;
      use_model  = 1'b1;
      man_active = 1'b0;
      man_done   = 1'b0;
      test_reset();
      test_single();
      test_round_robin();
      test_wrap();
      test_hung();
      test_simultaneous();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no end of run want finish before 1ms");
      $fatal(1, "simulation time limit");
   end

endmodule
